uart_pll_ctrl: RTL and testbench
================================

# uart_pll_ctrl

Reset and lock sequencer for the UART clock PLL. Runs in the `refclk` (50 MHz) domain. Drives the PLL's `rst`, watches its asynchronous `locked` output, and requires lock to hold continuously before declaring the UART clock usable. On timeout or lock loss it re-sequences the PLL, and after a bounded number of failed attempts it raises a sticky fault for the top level.

## Interface
Parameters:
- `RST_CYCLES`, default 16: width of the PLL reset pulse, in `refclk` cycles (≥1).
- `LOCK_TIMEOUT`, default 65536: maximum cycles to wait for lock after the PLL reset is released (≥2).
- `STABLE_CYCLES`, default 1024: cycles that synchronized lock must stay high before `ready` asserts (≥1).
- `MAX_RETRIES`, default 3: number of re-sequence attempts before entering FAIL (≥1).

Ports:
- `refclk`, input, 1: sole clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `restart`, input, 1: synchronous request to restart the sequence from scratch.
- `pll_locked`, input, 1: PLL `locked`; asynchronous to `refclk`.
- `pll_rst`, output, 1: drives the PLL `rst`.
- `ready`, output, 1: UART clock is locked and stable.
- `lock_lost`, output, 1: one-cycle pulse when lock drops while in READY.
- `fail`, output, 1: sticky fault; retries are exhausted.
- `retry_cnt`, output, `$clog2(MAX_RETRIES+1)`: retries used in the current sequence.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used internally.
- There is one shared cycle counter, `cnt`. Its width is `$clog2` of the largest of `RST_CYCLES`, `LOCK_TIMEOUT` and `STABLE_CYCLES`. It clears on every state change.
- All outputs are registered and update on the same edge as the state register:
  - `pll_rst` = 1 in RESET_PLL and FAIL.
  - `ready` = 1 in READY only.
- State RESET_PLL: hold `cnt` for `RST_CYCLES` cycles. On `cnt == RST_CYCLES-1`, go to WAIT_LOCK.
- State WAIT_LOCK:
  - If `locked_s` = 1, go to STABLE.
  - Otherwise, on `cnt == LOCK_TIMEOUT-1` (timeout):
    - if `retry_cnt == MAX_RETRIES`, go to FAIL;
    - else increment `retry_cnt` and go to RESET_PLL.
- State STABLE:
  - If `locked_s` = 0, apply the same retry/FAIL rule as a timeout. A flapping lock therefore consumes retries.
  - Otherwise, on `cnt == STABLE_CYCLES-1`, go to READY and clear `retry_cnt`.
- State READY:
  - If `locked_s` = 0, pulse `lock_lost` for one cycle, drop `ready`, and go to RESET_PLL.
  - `retry_cnt` stays 0 on this path (a fresh sequence).
- State FAIL: `fail` = 1 and `pll_rst` = 1. The state is held until `restart` or `rst`.
- `restart` = 1 in any state:
  - next state is RESET_PLL with `cnt` = 0 and `retry_cnt` = 0;
  - `fail`, `ready` and `lock_lost` are cleared.
  - `restart` has priority over every other transition, including the `lock_lost` pulse.
  - Holding `restart` high keeps the block in RESET_PLL with `cnt` held at 0.
- Simultaneous events:
  - timeout and `locked_s` rising on the same cycle: lock wins, go to STABLE.
  - `locked_s` falling on the final STABLE cycle: counts as a failure, not READY.

## Timing
- While `rst` is asserted and after it: state RESET_PLL, `cnt` = 0, `pll_rst` = 1, `ready` = 0, `lock_lost` = 0, `fail` = 0, `retry_cnt` = 0, synchronizer = 0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- `pll_rst` stays high for exactly `RST_CYCLES` rising edges after `rst` is released.
- If `pll_locked` rises before edge E:
  - `locked_s` = 1 after E+1;
  - STABLE is entered on E+2;
  - `ready` rises on edge E+2+`STABLE_CYCLES`.
- If `pll_locked` falls before edge E while in READY: `ready` falls and `lock_lost` = 1 on edge E+2, and `pll_rst` = 1 on that same edge.
- A timeout is declared `LOCK_TIMEOUT` cycles after entry to WAIT_LOCK.

## Test plan
Bench parameters: `RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- Nominal bring-up: release `rst`, raise `pll_locked` 10 cycles after `pll_rst` falls.
  - Required: `pll_rst` high for exactly 4 edges.
  - Required: `ready` rises on the 10th edge after `pll_locked` rises, with `retry_cnt` = 0.
- Timeout to FAIL: hold `pll_locked` low.
  - Required: `retry_cnt` steps 1, then 2.
  - Required: three 4-cycle `pll_rst` pulses separated by 32-cycle waits.
  - Required: FAIL with `fail` = 1 and `pll_rst` = 1 held; a 1-cycle `restart` returns to RESET_PLL with `fail` = 0.
- Flapping lock: drop `pll_locked` for 3 cycles at STABLE cycle 5.
  - Required: `retry_cnt` = 1, re-sequence occurs, `ready` = 0 throughout.
  - Required: a later clean lock gives `ready` = 1 and `retry_cnt` = 0.
- Lock loss in READY: drop `pll_locked`.
  - Required: single-cycle `lock_lost`, `ready` = 0, `pll_rst` = 1 on the same edge, `retry_cnt` = 0.
  - Required: re-lock restores `ready`.
- Async reset and restart priority:
  - Assert `rst` between edges in STABLE: all outputs return to reset values immediately.
  - Assert `restart` on the same cycle as lock loss in READY: no `lock_lost` pulse, RESET_PLL entered.

Source files
------------

// File: rtl/uart_pll_ctrl.sv
// Reset and lock sequencer for the UART clock PLL: pulses the PLL reset, waits for a
// synchronized lock to hold, retries on timeout or lock loss, and latches a fault.
module uart_pll_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               restart,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    output logic                               ready,
    output logic                               lock_lost,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

    localparam int RW      = $clog2(MAX_RETRIES + 1);
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_READY,
        S_FAIL
    } state_t;

    logic [1:0]       sync_q;
    logic             locked_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             ready_q, ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic             fail_q, fail_d;
    logic             attempt_failed;

    assign locked_s = sync_q[1];

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d        = state_q;
        retry_d        = retry_q;
        lock_lost_d    = 1'b0;
        attempt_failed = 1'b0;

        if (restart) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    // Lock beats a coincident timeout.
                    if (locked_s)                   state_d = S_STABLE;
                    else if (cnt_q == TIMEOUT_LAST) attempt_failed = 1'b1;
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        attempt_failed = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_READY;
                        retry_d = '0;
                    end
                end
                S_READY: begin
                    if (!locked_s) begin
                        state_d     = S_RESET_PLL;
                        lock_lost_d = 1'b1;
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_RESET_PLL;
            endcase

            if (attempt_failed) begin
                if (retry_q == RETRY_MAX) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_RESET_PLL;
                    retry_d = retry_q + RW'(1);
                end
            end
        end

        // The counter only runs in timed states and restarts on every state change.
        if (restart || (state_d != state_q) || (state_q == S_READY) || (state_q == S_FAIL))
            cnt_d = '0;
        else
            cnt_d = cnt_q + CNT_W'(1);

        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        ready_d   = (state_d == S_READY);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sync_q      <= {sync_q[0], pll_locked};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_uart_pll_ctrl.sv
// Scoreboarded bench for uart_pll_ctrl: stimulus queues each expected output change with the
// edge number it must appear on; a negedge monitor compares every observed change in order.
module tb_uart_pll_ctrl;

    localparam int RW = 2;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    logic          refclk = 1'b0;
    logic          rst;
    logic          restart;
    logic          pll_locked;
    logic          pll_rst;
    logic          ready;
    logic          lock_lost;
    logic          fail;
    logic [RW-1:0] retry_cnt;

    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    exp_t sb_q[$];
    logic [5:0] prev = 6'b100000;

    uart_pll_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .restart   (restart),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) edge_n <= edge_n + 1;

    // Output vector layout: {pll_rst, ready, lock_lost, fail, retry_cnt[1:0]}
    function automatic logic [5:0] outv();
        return {pll_rst, ready, lock_lost, fail, retry_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic push(input int cyc, input logic [5:0] vec);
        exp_t e;
        e.cyc = cyc;
        e.vec = vec;
        sb_q.push_back(e);
    endtask

    // Ends 2 time units after the posedge numbered target (target must lie in the future).
    task automatic wait_to(input int target);
        while (edge_n < target) begin
            @(posedge refclk);
            #1;
        end
        #1;
    endtask

    always @(negedge refclk) begin
        if (mon_en) begin
            logic [5:0] cur;
            exp_t       e;
            cur = outv();
            if (cur !== prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_change", {26'd0, cur}, {26'd0, prev});
                end else begin
                    e = sb_q.pop_front();
                    check("change_edge", edge_n, e.cyc);
                    check("change_value", {26'd0, cur}, {26'd0, e.vec});
                end
                prev = cur;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, w, s, f, m;
        rst        = 1'b1;
        restart    = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(posedge refclk);
        #2;
        check("reset_state", {26'd0, outv()}, 32'h20);
        mon_en = 1'b1;

        // Nominal bring-up: pll_rst falls on the 4th edge, lock 10 cycles later.
        n = edge_n;
        rst = 1'b0;
        push(n + 4, 6'b000000);
        w = n + 4;
        wait_to(w + 10);
        pll_locked = 1'b1;
        push(w + 21, 6'b010000);
        wait_to(w + 24);

        // Lock loss in READY, then re-lock.
        n = edge_n;
        pll_locked = 1'b0;
        push(n + 3, 6'b101000);
        push(n + 4, 6'b100000);
        push(n + 7, 6'b000000);
        wait_to(n + 7);
        pll_locked = 1'b1;
        push(n + 18, 6'b010000);
        wait_to(n + 20);

        // Restart from READY, then a 3-cycle lock drop inside STABLE.
        n = edge_n;
        restart = 1'b1;
        push(n + 1, 6'b100000);
        wait_to(n + 1);
        restart = 1'b0;
        push(n + 5, 6'b000000);
        s = n + 6;
        wait_to(s + 4);
        pll_locked = 1'b0;
        push(s + 7, 6'b100001);
        wait_to(s + 7);
        pll_locked = 1'b1;
        push(s + 11, 6'b000001);
        push(s + 20, 6'b010000);
        wait_to(s + 22);

        // Lock lost and never returns: two retries, then FAIL, then restart.
        n = edge_n;
        pll_locked = 1'b0;
        push(n + 3,   6'b101000);
        push(n + 4,   6'b100000);
        push(n + 7,   6'b000000);
        push(n + 39,  6'b100001);
        push(n + 43,  6'b000001);
        push(n + 75,  6'b100010);
        push(n + 79,  6'b000010);
        push(n + 111, 6'b100110);
        wait_to(n + 125);
        f = edge_n;
        restart = 1'b1;
        push(f + 1, 6'b100000);
        wait_to(f + 1);
        restart = 1'b0;
        push(f + 5, 6'b000000);
        wait_to(f + 5);
        pll_locked = 1'b1;
        push(f + 16, 6'b010000);
        wait_to(f + 18);

        // Asynchronous reset between edges while in STABLE.
        n = edge_n;
        restart = 1'b1;
        push(n + 1, 6'b100000);
        wait_to(n + 1);
        restart = 1'b0;
        push(n + 5, 6'b000000);
        wait_to(n + 8);
        rst = 1'b1;
        push(n + 8, 6'b100000);
        #1;
        check("async_reset", {26'd0, outv()}, 32'h20);
        wait_to(n + 10);
        m = edge_n;
        rst = 1'b0;
        push(m + 4, 6'b000000);
        push(m + 13, 6'b010000);
        wait_to(m + 15);

        // Restart coincides with lock loss in READY: no lock_lost pulse.
        n = edge_n;
        pll_locked = 1'b0;
        wait_to(n + 2);
        restart = 1'b1;
        push(n + 3, 6'b100000);
        wait_to(n + 3);
        restart = 1'b0;
        push(n + 7, 6'b000000);
        wait_to(n + 7);
        pll_locked = 1'b1;
        push(n + 18, 6'b010000);
        wait_to(n + 22);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
